// File: rtl/seq_array_multiplier_if.sv
// Operand/result bus of the iterative multiplier: request side drives operands and
// control, the multiplier returns busy/done and the held product.
interface seq_array_multiplier_if #(
    parameter int unsigned WIDTH = 4
);
    logic               start;
    logic               signed_mode;
    logic               clear;
    logic [WIDTH-1:0]   a;
    logic [WIDTH-1:0]   b;
    logic               busy;
    logic               done;
    logic [2*WIDTH-1:0] product;

    modport master (
        output start, signed_mode, clear, a, b,
        input  busy, done, product
    );

    modport slave (
        input  start, signed_mode, clear, a, b,
        output busy, done, product
    );
endinterface

// File: rtl/seq_array_multiplier.sv
// Iterative shift-add WIDTH x WIDTH multiplier, one partial product per cycle, with
// runtime signed/unsigned mode, start/done handshake and synchronous abort.
module seq_array_multiplier #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    seq_array_multiplier_if.slave   bus
);
    localparam int unsigned PW = 2 * WIDTH;
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state_q, state_d;
    logic [PW-1:0]    a_ext_q, a_ext_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    count_q, count_d;
    logic [PW-1:0]    product_q, product_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             accept_c;
    logic             last_c;
    logic [PW-1:0]    pp_c;
    logic [PW-1:0]    acc_next_c;

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.product = product_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            a_ext_q   <= '0;
            b_q       <= '0;
            signed_q  <= 1'b0;
            acc_q     <= '0;
            count_q   <= '0;
            product_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            a_ext_q   <= a_ext_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            acc_q     <= acc_d;
            count_q   <= count_d;
            product_q <= product_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // clear has priority over start in IDLE and aborts a running operation
    always_comb begin
        accept_c = (state_q == IDLE) && bus.start && !bus.clear;
        last_c   = (count_q == CW'(WIDTH - 1));
        state_d  = state_q;
        case (state_q)
            IDLE:    if (accept_c) state_d = RUN;
            RUN:     if (bus.clear || last_c) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The multiplier MSB carries weight -2^(WIDTH-1) in signed mode, hence the final subtract
    always_comb begin
        pp_c       = b_q[count_q] ? (a_ext_q << count_q) : '0;
        acc_next_c = (last_c && signed_q) ? (acc_q - pp_c) : (acc_q + pp_c);

        a_ext_d   = a_ext_q;
        b_d       = b_q;
        signed_d  = signed_q;
        acc_d     = acc_q;
        count_d   = count_q;
        product_d = product_q;
        done_d    = 1'b0;
        busy_d    = (state_d == RUN);

        case (state_q)
            IDLE: begin
                if (accept_c) begin
                    a_ext_d  = bus.signed_mode ? {{WIDTH{bus.a[WIDTH-1]}}, bus.a}
                                               : {{WIDTH{1'b0}}, bus.a};
                    b_d      = bus.b;
                    signed_d = bus.signed_mode;
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            RUN: begin
                if (!bus.clear) begin
                    acc_d   = acc_next_c;
                    count_d = count_q + CW'(1);
                    if (last_c) begin
                        product_d = acc_next_c;
                        done_d    = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end
endmodule
